// File: rtl/pka_operand_loader_if.sv
// pka_operand_loader_if: 32-bit operand word stream with valid/ready handshake,
// frame-end marker and per-frame RSA mode bit.
interface pka_operand_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_is_rsa;
  modport master (output in_valid, in_data, in_last, in_is_rsa, input in_ready);
  modport slave  (input in_valid, in_data, in_last, in_is_rsa, output in_ready);
endinterface

// File: rtl/pka_operand_loader.sv
// pka_operand_loader: assembles n, d, m from a word stream and launches the PKA engine.
// Optional even-modulus rejection when PKA_LOADER_MODCHK_EN is defined.
module pka_operand_loader #(
  parameter int KEY_SIZE = 2048
) (
  input  logic                 clk,
  input  logic                 rstn,
  pka_operand_loader_if.slave  s_in,
  input  logic                 clr,
  input  logic                 eng_done,
  output logic [KEY_SIZE-1:0]  n,
  output logic [KEY_SIZE-1:0]  d,
  output logic [KEY_SIZE-1:0]  m,
  output logic                 is_rsa,
  output logic                 start,
  output logic                 busy,
  output logic                 err
);
  localparam int NUM_WORDS = KEY_SIZE / 32;
  localparam int WW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(NUM_WORDS - 1);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, ERR} state_t;
  state_t r_state, w_next;
  logic [WW-1:0] r_word;
  logic [1:0] r_op;
  logic [KEY_SIZE-1:0] r_n, r_d, r_m;
  logic r_is_rsa;
  logic w_hs, w_wrap, w_final, w_first, w_modfail, w_bad;
  assign w_hs    = s_in.in_valid & (r_state == LOAD);
  assign w_wrap  = r_word == LAST_W;
  assign w_final = (r_op == 2'd2) & w_wrap;
  assign w_first = (r_op == 2'd0) & (r_word == '0);
`ifdef PKA_LOADER_MODCHK_EN
  assign w_modfail = ~r_n[0];
`else
  assign w_modfail = 1'b0;
`endif
  // a misplaced or missing in_last, or a rejected modulus, discards the word and aborts
  assign w_bad = w_final ? (~s_in.in_last | w_modfail) : s_in.in_last;
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    w_next = !w_hs ? LOAD : w_bad ? ERR : w_final ? ISSUE : LOAD;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = eng_done ? LOAD : WAIT;
      default: w_next = clr ? LOAD : ERR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= LOAD;
      r_word   <= '0;
      r_op     <= '0;
      r_n      <= '0;
      r_d      <= '0;
      r_m      <= '0;
      r_is_rsa <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_word <= (w_bad | w_wrap) ? '0 : r_word + 1'b1;
        r_op   <= (w_bad | w_final) ? 2'd0 : w_wrap ? r_op + 2'd1 : r_op;
      end
      if (w_hs & ~w_bad) begin
        if (r_op == 2'd0) r_n[{r_word, 5'b0} +: 32] <= s_in.in_data;
        else if (r_op == 2'd1) r_d[{r_word, 5'b0} +: 32] <= s_in.in_data;
        else r_m[{r_word, 5'b0} +: 32] <= s_in.in_data;
        if (w_first) r_is_rsa <= s_in.in_is_rsa;
      end
      if (r_state == ERR && clr) begin
        r_n <= '0;
        r_d <= '0;
        r_m <= '0;
      end
    end
  end
  assign s_in.in_ready = r_state == LOAD;
  assign start  = r_state == ISSUE;
  assign busy   = (r_state == ISSUE) | (r_state == WAIT);
  assign err    = r_state == ERR;
  assign n      = r_n;
  assign d      = r_d;
  assign m      = r_m;
  assign is_rsa = r_is_rsa;
endmodule

// File: tb/tb_pka_operand_loader.sv
// tb_pka_operand_loader: directed frames against a frame-level model, KEY_SIZE=64.
module tb_pka_operand_loader;
  localparam int KS = 64;
  localparam int NW = KS / 32;
  logic clk = 0, rstn = 0, clr = 0, eng_done = 0;
  logic [KS-1:0] n, d, m;
  logic is_rsa, start, busy, err;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;
  pka_operand_loader_if bus();
  pka_operand_loader #(.KEY_SIZE(KS)) dut (
    .clk(clk), .rstn(rstn), .s_in(bus), .clr(clr), .eng_done(eng_done),
    .n(n), .d(d), .m(m), .is_rsa(is_rsa), .start(start), .busy(busy), .err(err));
  always #5 clk = ~clk;
  // model: counts accepted words of the current frame and places them by position
  logic [KS-1:0] e_op[3];
  logic e_rsa, e_ready, e_start, e_busy, e_err;
  int pos;
  always @(posedge clk) begin
    if (!rstn) begin
      pos = 0; e_op[0] = 0; e_op[1] = 0; e_op[2] = 0;
      e_rsa = 0; e_ready = 1; e_start = 0; e_busy = 0; e_err = 0;
    end else if (e_start) e_start = 0;
    else if (e_busy) begin
      if (eng_done) begin e_busy = 0; e_ready = 1; end
    end else if (e_err) begin
      if (clr) begin e_err = 0; e_ready = 1; e_op[0] = 0; e_op[1] = 0; e_op[2] = 0; end
    end else if (bus.in_valid) begin
      bit fin, rej;
      fin = pos == 3 * NW - 1;
      rej = 0;
`ifdef PKA_LOADER_MODCHK_EN
      rej = e_op[0][0] == 1'b0;
`endif
      if (fin ? (!bus.in_last || rej) : bus.in_last) begin
        e_err = 1; e_ready = 0; pos = 0;
      end else begin
        e_op[pos / NW][32 * (pos % NW) +: 32] = bus.in_data;
        if (pos == 0) e_rsa = bus.in_is_rsa;
        if (fin) begin e_start = 1; e_busy = 1; e_ready = 0; pos = 0; end
        else pos++;
      end
    end
  end
  task automatic chk(string name, logic [KS-1:0] act, logic [KS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", KS'(bus.in_ready), KS'(e_ready));
    chk("start", KS'(start), KS'(e_start));
    chk("busy", KS'(busy), KS'(e_busy));
    chk("err", KS'(err), KS'(e_err));
    chk("is_rsa", KS'(is_rsa), KS'(e_rsa));
    chk("n", n, e_op[0]);
    chk("d", d, e_op[1]);
    chk("m", m, e_op[2]);
  end
  task automatic send(logic [31:0] data, logic last, logic rsa);
    bus.in_valid = 1; bus.in_data = data; bus.in_last = last; bus.in_is_rsa = rsa;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.in_last = 0; bus.in_is_rsa = 0;
  endtask
  task automatic cyc(int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_done();
    eng_done = 1; cyc(1); eng_done = 0;
  endtask
  task automatic pulse_clr();
    clr = 1; cyc(1); clr = 0;
  endtask
  task automatic frame(logic [31:0] w[6], int last_at, logic rsa);
    for (int i = 0; i < 6; i++) send(w[i], i == last_at, i == 0 ? rsa : 1'b0);
  endtask
  logic [31:0] fa[6] = '{32'hD, 32'h0, 32'h5, 32'h0, 32'h2, 32'h0};
  logic [31:0] fb[6] = '{32'h11, 32'h1, 32'h22, 32'h2, 32'h33, 32'h3};
  logic [31:0] fc[6] = '{32'hC, 32'h0, 32'h7, 32'h0, 32'h9, 32'h0};
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.in_is_rsa = 0;
    cyc(2);
    chk_en = 1;
    chk("rst n", n, 64'h0);
    chk("rst err", KS'(err), 64'h0);
    rstn = 1;
    cyc(1);
    chk("ready after reset", KS'(bus.in_ready), 64'h1);
    // nominal frame
    frame(fa, 5, 1'b1);
    chk("A start", KS'(start), 64'h1);
    chk("A n", n, 64'hD);
    chk("A d", d, 64'h5);
    chk("A m", m, 64'h2);
    chk("A is_rsa", KS'(is_rsa), 64'h1);
    chk("A ready", KS'(bus.in_ready), 64'h0);
    cyc(1);
    chk("A start once", KS'(start), 64'h0);
    chk("A busy", KS'(busy), 64'h1);
    bus.in_valid = 1; bus.in_data = 32'hFFFF_FFFF; cyc(3); bus.in_valid = 0;
    pulse_done();
    chk("done ready", KS'(bus.in_ready), 64'h1);
    chk("done busy", KS'(busy), 64'h0);
    chk("done n kept", n, 64'hD);
    pulse_done(); clr = 1; cyc(1); clr = 0;
    frame(fb, 5, 1'b0);
    chk("B n", n, 64'h1_0000_0011);
    chk("B m", m, 64'h3_0000_0033);
    chk("B is_rsa", KS'(is_rsa), 64'h0);
    cyc(2); pulse_done();
    // early in_last on word 4
    for (int i = 0; i < 4; i++) send(fa[i], i == 3, 1'b1);
    chk("early err", KS'(err), 64'h1);
    chk("early ready", KS'(bus.in_ready), 64'h0);
    cyc(2); eng_done = 1; cyc(1); eng_done = 0;
    chk("early no start", KS'(start), 64'h0);
    pulse_clr();
    chk("clr err", KS'(err), 64'h0);
    chk("clr ready", KS'(bus.in_ready), 64'h1);
    chk("clr n", n, 64'h0);
    // missing in_last on final word
    frame(fa, 6, 1'b1);
    chk("nolast err", KS'(err), 64'h1);
    chk("nolast start", KS'(start), 64'h0);
    pulse_clr();
    // even modulus
    frame(fc, 5, 1'b1);
`ifdef PKA_LOADER_MODCHK_EN
    chk("even err", KS'(err), 64'h1);
    chk("even start", KS'(start), 64'h0);
    pulse_clr();
`else
    chk("even start", KS'(start), 64'h1);
    chk("even n", n, 64'hC);
    cyc(1); pulse_done();
`endif
    // reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) send(fb[i], 1'b0, 1'b1);
    rstn = 0; cyc(1); rstn = 1;
    chk("midrst n", n, 64'h0);
    chk("midrst is_rsa", KS'(is_rsa), 64'h0);
    chk("midrst ready", KS'(bus.in_ready), 64'h1);
    frame(fa, 5, 1'b1);
    chk("R start", KS'(start), 64'h1);
    chk("R n", n, 64'hD);
    chk("R d", d, 64'h5);
    chk("R m", m, 64'h2);
    // reset during WAIT
    cyc(2); rstn = 0; cyc(1); rstn = 1;
    chk("waitrst busy", KS'(busy), 64'h0);
    chk("waitrst m", m, 64'h0);
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
